// File: rtl/dmem_if.sv
// dmem_if: two-port request/ack bundle between masters and the data-memory arbiter.
interface dmem_if #(
    parameter int W = 8,
    parameter int A = 8
);
    logic         req0, we0, ack0;
    logic [A-1:0] addr0;
    logic [W-1:0] wdata0;
    logic         req1, we1, ack1;
    logic [A-1:0] addr1;
    logic [W-1:0] wdata1;
    logic [W-1:0] rdata;
    modport slave  (input  req0, we0, addr0, wdata0, req1, we1, addr1, wdata1,
                    output ack0, ack1, rdata);
    modport master (output req0, we0, addr0, wdata0, req1, we1, addr1, wdata1,
                    input  ack0, ack1, rdata);
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: serialises two ports onto a single-ported memory, round-robin on ties,
// registered read data, one-cycle ack and saturating per-port grant counters.
module dmem_arbiter #(
    parameter int W  = 8,
    parameter int A  = 8,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    dmem_if.slave         bus,
    output logic          mem_we_o,
    output logic [A-1:0]  mem_addr_o,
    output logic [W-1:0]  mem_wdata_o,
    input  logic [W-1:0]  mem_rdata_i,
    output logic          busy_o,
    output logic [CW-1:0] cnt0_o,
    output logic [CW-1:0] cnt1_o
);
    typedef enum logic [1:0] {IDLE, SERVE, ACK} state_t;
    state_t        state_q, state_d;
    logic          port_q, we_q, last_q, gnt, req;
    logic [A-1:0]  addr_q;
    logic [W-1:0]  wdata_q, rdata_q;
    logic [CW-1:0] cnt0_q, cnt1_q;

    assign req = bus.req0 | bus.req1;
    // port 1 wins when it is the sole requester, or on a tie when port 0 went last
    assign gnt = bus.req1 & (~bus.req0 | ~last_q);

    always_comb begin
        state_d = IDLE;
        state_d = state_q == IDLE  ? (req ? SERVE : IDLE) :
                  state_q == SERVE ? ACK : IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            port_q  <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            last_q  <= 1'b1;
            cnt0_q  <= '0;
            cnt1_q  <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && req) begin
                port_q  <= gnt;
                we_q    <= gnt ? bus.we1    : bus.we0;
                addr_q  <= gnt ? bus.addr1  : bus.addr0;
                wdata_q <= gnt ? bus.wdata1 : bus.wdata0;
            end
            if (state_q == SERVE && !we_q) rdata_q <= mem_rdata_i;
            if (state_q == ACK) begin
                last_q <= port_q;
                if (port_q) cnt1_q <= cnt1_q + CW'(~&cnt1_q);
                else        cnt0_q <= cnt0_q + CW'(~&cnt0_q);
            end
        end
    end

    // memory port is combinational from state so an async reset kills MemWe at once
    assign mem_we_o    = state_q == SERVE && we_q;
    assign mem_addr_o  = state_q == SERVE ? addr_q  : '0;
    assign mem_wdata_o = state_q == SERVE ? wdata_q : '0;
    assign bus.ack0    = state_q == ACK && !port_q;
    assign bus.ack1    = state_q == ACK && port_q;
    assign bus.rdata   = rdata_q;
    assign busy_o      = state_q != IDLE;
    assign cnt0_o      = cnt0_q;
    assign cnt1_o      = cnt1_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed checks of the arbiter against a behavioural memory;
// a second CW=2 instance covers counter saturation.
module tb_dmem_arbiter;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       mem_we, mem_we2;
    logic [7:0] mem_addr, mem_wdata, mem_rdata, mem_addr2, mem_wdata2, mem_rdata2;
    logic [15:0] cnt0, cnt1;
    logic [1:0]  cnt0b, cnt1b;
    logic        busy, busy2;
    logic [7:0]  mem [256];
    int passed = 0;
    int total = 0;

    dmem_if #(.W(8), .A(8)) b  ();
    dmem_if #(.W(8), .A(8)) b2 ();

    dmem_arbiter #(.W(8), .A(8), .CW(16)) dut (
        .clk(clk), .rst_n(rst_n), .bus(b),
        .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
        .mem_rdata_i(mem_rdata), .busy_o(busy), .cnt0_o(cnt0), .cnt1_o(cnt1));

    dmem_arbiter #(.W(8), .A(8), .CW(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .bus(b2),
        .mem_we_o(mem_we2), .mem_addr_o(mem_addr2), .mem_wdata_o(mem_wdata2),
        .mem_rdata_i(mem_rdata2), .busy_o(busy2), .cnt0_o(cnt0b), .cnt1_o(cnt1b));

    always #5 clk = ~clk;
    always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;
    assign mem_rdata  = mem[mem_addr];
    assign mem_rdata2 = mem[mem_addr2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int acks;
        logic we_seen;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        {b.req0, b.we0, b.req1, b.we1} = '0;
        {b.addr0, b.addr1, b.wdata0, b.wdata1} = '0;
        {b2.req0, b2.we0, b2.req1, b2.we1} = '0;
        {b2.addr0, b2.addr1, b2.wdata0, b2.wdata1} = '0;
        step();
        chk("rst_busy", busy, 0);
        chk("rst_ack", {b.ack0, b.ack1}, 0);
        chk("rst_mem", {mem_we, mem_addr, mem_wdata}, 0);
        chk("rst_cnt", {cnt0, cnt1}, 0);
        chk("rst_rdata", b.rdata, 0);
        rst_n = 1'b1;
        // reset mid-SERVE of a write
        b.req0 = 1; b.we0 = 1; b.addr0 = 8'h10; b.wdata0 = 8'hAA;
        step();
        chk("t1_serve_we", mem_we, 1);
        rst_n = 1'b0;
        #1;
        chk("t1_we_drop", mem_we, 0);
        chk("t1_busy", busy, 0);
        b.req0 = 0;
        step();
        chk("t1_no_ack", b.ack0, 0);
        chk("t1_mem", mem[8'h10], 8'h00);
        rst_n = 1'b1;
        step();
        // port 0 write then read
        b.req0 = 1; b.we0 = 1; b.addr0 = 8'h10; b.wdata0 = 8'h5A;
        step();
        chk("t2_w_serve_addr", mem_addr, 8'h10);
        chk("t2_w_serve_we", mem_we, 1);
        step();
        chk("t2_w_ack", {b.ack0, b.ack1}, 2'b10);
        b.req0 = 0;
        step();
        chk("t2_w_mem", mem[8'h10], 8'h5A);
        chk("t2_w_cnt0", cnt0, 1);
        chk("t2_w_ack_off", b.ack0, 0);
        b.req0 = 1; b.we0 = 0;
        step();
        chk("t2_r_serve", {mem_we, mem_addr}, {1'b0, 8'h10});
        step();
        chk("t2_r_ack", {b.ack0, b.ack1}, 2'b10);
        chk("t2_r_data", b.rdata, 8'h5A);
        b.req0 = 0;
        step();
        chk("t2_r_cnt0", cnt0, 2);
        chk("t2_r_hold", b.rdata, 8'h5A);
        // port 1 read, port 0 idle
        chk("t4_idle_addr", mem_addr, 0);
        b.req1 = 1; b.we1 = 0; b.addr1 = 8'h10;
        step();
        chk("t4_serve_addr", mem_addr, 8'h10);
        step();
        chk("t4_ack", {b.ack0, b.ack1}, 2'b01);
        chk("t4_addr_ack", mem_addr, 0);
        b.req1 = 0;
        step();
        chk("t4_cnt1", cnt1, 1);
        chk("t4_cnt0", cnt0, 2);
        // Req0 dropped during SERVE; late data change ignored
        b.req0 = 1; b.we0 = 1; b.addr0 = 8'h20; b.wdata0 = 8'h33;
        step();
        b.req0 = 0; b.wdata0 = 8'hFF;
        #1;
        chk("t5_wdata", mem_wdata, 8'h33);
        step();
        chk("t5_ack", b.ack0, 1);
        step();
        chk("t5_mem", mem[8'h20], 8'h33);
        chk("t5_cnt0", cnt0, 3);
        chk("t5_rdata_kept", b.rdata, 8'h5A);
        step();
        chk("t5_idle", busy, 0);
        // both ports held from reset: grants alternate 0,1,0,1
        rst_n = 1'b0;
        b.we0 = 0; b.we1 = 0; b.addr0 = 8'h10; b.addr1 = 8'h20;
        b.req0 = 1; b.req1 = 1;
        step();
        rst_n = 1'b1;
        for (int g = 0; g < 4; g++) begin
            step();
            chk("t3_busy", busy, 1);
            step();
            chk("t3_ack", {b.ack0, b.ack1}, (g % 2 == 0) ? 2'b10 : 2'b01);
            chk("t3_rdata", b.rdata, (g % 2 == 0) ? 8'h5A : 8'h33);
            if (g == 3) begin b.req0 = 0; b.req1 = 0; end
            step();
        end
        chk("t3_cnt", {cnt0, cnt1}, {16'd2, 16'd2});
        chk("t3_idle", busy, 0);
        // CW=2 saturation over 5 back-to-back reads
        acks = 0; we_seen = 0;
        b2.req0 = 1; b2.we0 = 0; b2.addr0 = 8'h20;
        for (int t = 1; t <= 15; t++) begin
            if (t == 15) b2.req0 = 0;
            step();
            we_seen |= mem_we2;
            if (b2.ack0) acks++;
            if (t == 9) chk("t6_cnt_at3", cnt0b, 3);
        end
        chk("t6_acks", acks, 5);
        chk("t6_sat", cnt0b, 3);
        chk("t6_no_we", we_seen, 0);
        chk("t6_rdata", b2.rdata, 8'h33);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
